irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt entry/exit controller for the 4-phase (Q0–Q3) PIC16 core.
- Watches masked interrupt flags and global enable, then waits for the current instruction to finish.
- Injects two forced-NOP instruction cycles. Across those cycles it pushes PC, clears GIE, jumps to the vector and flushes the prefetched instruction.
- Tracks in-service state until RETFIE completes. Sits beside the instruction decoder, driving its NOP override and the PC/stack load strobes.

Parameters:
- NUM_IRQ, 4, number of interrupt sources.
- PC_WIDTH, 13, program counter width.
- VECTOR_ADDR, 13'h004, interrupt vector loaded into PC.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- q_count  in  2  current Q phase, 0..3, shared with the decoder.
- irq_flags  in  NUM_IRQ  interrupt flag bits (xxIF).
- irq_enables  in  NUM_IRQ  per-source enables (xxIE).
- gie  in  1  INTCON.GIE current value.
- instr_done  in  1  high during Q3 of the final cycle of a real (non-injected) instruction.
- instr_is_retfie  in  1  current instruction decodes as RETFIE; qualified by instr_done.
- force_nop  out  1  decoder must execute NOP instead of instr_current.
- stack_push  out  1  push the current PC onto the hardware stack (1-clk pulse).
- pc_load_vector  out  1  load PC with vector_addr (1-clk pulse).
- vector_addr  out  PC_WIDTH  constant VECTOR_ADDR.
- instr_flush  out  1  discard the prefetched instruction (1-clk pulse).
- gie_clr  out  1  clear INTCON.GIE (1-clk pulse).
- gie_set  out  1  set INTCON.GIE (1-clk pulse).
- irq_active  out  1  high while states are INJ1, INJ2 or ISR.

Behaviour:
- All outputs registered or decoded from registered state. On rst: state=IDLE; every output 0 except vector_addr (constant).
- req = gie & |(irq_flags & irq_enables), evaluated combinationally every clk.
- States: IDLE, PEND, INJ1, INJ2, ISR.
- IDLE:
  - req=1 → PEND on the next clk edge, in any Q phase.
- PEND:
  - req=0 before the boundary → IDLE. The request is cancelled; nothing is injected.
  - instr_done=1 with req=1 → INJ1. An instruction already in progress always completes.
  - If instr_done and instr_is_retfie occur together in PEND, treat it as a normal boundary → INJ1.
- INJ1 (one full 4-Q instruction cycle):
  - force_nop=1 throughout.
  - At q_count==3: stack_push=1, pc_load_vector=1, gie_clr=1 for that single clk; then → INJ2.
  - The pushed PC is the address of the next unexecuted instruction, i.e. the decoder's PC after the boundary increment.
- INJ2:
  - force_nop=1 throughout.
  - At q_count==3: instr_flush=1 for one clk; then → ISR.
  - Interrupt latency from boundary to first ISR instruction is exactly 8 clks.
- ISR:
  - force_nop=0. req is ignored, including if software re-sets GIE; there is no nesting.
  - instr_done & instr_is_retfie → gie_set=1 for that clk, → IDLE.
  - A req still pending after RETFIE is seen only once gie reads 1, so the earliest re-entry is IDLE → PEND on the following clk.
- instr_done is ignored in INJ1/INJ2. Injected NOPs are sequenced solely by q_count.
- Entry into INJ1 always happens at a q_count==3 edge, so INJ1 starts at Q0.
- Reset mid-injection:
  - Asynchronous return to IDLE with outputs 0.
  - If reset arrives before INJ1 Q3, no push, vector load or GIE clear occurs.
- At most one of stack_push/instr_flush/gie_set is high in any clk, except the three INJ1 Q3 pulses, which coincide by design.

Optional Feature:
- Macro IRQ_LATENCY_CNT_EN.
- Defined:
  - Adds output irq_latency [7:0].
  - A saturating counter (max 255) counts clks spent in PEND and is cleared on PEND entry.
  - Its value is captured into irq_latency on the INJ1 Q3 edge and held until the next capture. Reset value 0.
- Undefined:
  - Port and counter are absent; the behaviour above is unchanged.

Test Plan:
- gie=1, irq_enables=4'b0001, raise irq_flags[0] mid-instruction → PEND; after instr_done: 4 clks force_nop, then stack_push/pc_load_vector/gie_clr pulse at INJ1 Q3 (vector_addr=13'h004); 4 clks later instr_flush; then irq_active=1, state ISR.
- irq_flags=4'b0010, irq_enables=4'b0001, gie=1 → no state change; outputs stay 0 for 32 clks.
- In PEND, drop irq_flags to 0 before instr_done → returns to IDLE; no stack_push, no force_nop.
- In ISR, assert flag with gie forced 1 → ignored; then instr_done+instr_is_retfie → gie_set pulse, IDLE; with flag still set and gie=1, PEND on the next clk.
- Assert rst during INJ1 at q_count==1 → all outputs 0 immediately; stack_push never pulses.
- With IRQ_LATENCY_CNT_EN: request 6 clks before instr_done → irq_latency=6 after INJ1 Q3; a PEND stay of 300 clks → irq_latency=255.

Source files
------------

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Purpose  : Interrupt entry/exit controller for the 4-phase (Q0-Q3) PIC16
//            core. Watches the masked interrupt flags and GIE, lets the
//            current instruction finish, then injects two forced-NOP cycles:
//            INJ1 Q3 pushes PC, loads the vector and clears GIE; INJ2 Q3
//            flushes the prefetched instruction. In-service state is held
//            until RETFIE completes (no nesting).
// Ports    : clk, rst (async, active high), q_count[1:0],
//            irq_flags/irq_enables[NUM_IRQ-1:0], gie, instr_done,
//            instr_is_retfie  -> force_nop, stack_push, pc_load_vector,
//            vector_addr[PC_WIDTH-1:0], instr_flush, gie_clr, gie_set,
//            irq_active [, irq_latency[7:0]]
// Options  : IRQ_LATENCY_CNT_EN adds irq_latency, a saturating count of the
//            clocks spent in PEND, captured on the INJ1 Q3 edge.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
  parameter int                   NUM_IRQ     = 4,
  parameter int                   PC_WIDTH    = 13,
  parameter logic [PC_WIDTH-1:0]  VECTOR_ADDR = 13'h004
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          q_count,
  input  logic [NUM_IRQ-1:0]  irq_flags,
  input  logic [NUM_IRQ-1:0]  irq_enables,
  input  logic                gie,
  input  logic                instr_done,
  input  logic                instr_is_retfie,
  output logic                force_nop,
  output logic                stack_push,
  output logic                pc_load_vector,
  output logic [PC_WIDTH-1:0] vector_addr,
  output logic                instr_flush,
  output logic                gie_clr,
  output logic                gie_set,
`ifdef IRQ_LATENCY_CNT_EN
  output logic [7:0]          irq_latency,
`endif
  output logic                irq_active
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_INJ1 = 3'd2,
    ST_INJ2 = 3'd3,
    ST_ISR  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic req;
  logic q_last;
  logic retfie_done;

  assign req         = gie & (|(irq_flags & irq_enables));
  assign q_last      = (q_count == 2'd3);
  assign retfie_done = instr_done & instr_is_retfie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and decoded outputs. The strobes are decoded from the
  // registered state plus the shared Q-phase counter, so an asynchronous
  // reset removes them immediately.
  always_comb begin
    state_nxt      = state;
    force_nop      = 1'b0;
    stack_push     = 1'b0;
    pc_load_vector = 1'b0;
    instr_flush    = 1'b0;
    gie_clr        = 1'b0;
    gie_set        = 1'b0;
    irq_active     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req) state_nxt = ST_PEND;
      end

      ST_PEND: begin
        // A cancelled request wins; otherwise wait for the running
        // instruction's boundary. RETFIE at the boundary is an ordinary
        // boundary here because we are not in service yet.
        if (!req) begin
          state_nxt = ST_IDLE;
        end else if (instr_done) begin
          state_nxt = ST_INJ1;
        end
      end

      ST_INJ1: begin
        force_nop  = 1'b1;
        irq_active = 1'b1;
        if (q_last) begin
          // The three entry strobes deliberately coincide.
          stack_push     = 1'b1;
          pc_load_vector = 1'b1;
          gie_clr        = 1'b1;
          state_nxt      = ST_INJ2;
        end
      end

      ST_INJ2: begin
        force_nop  = 1'b1;
        irq_active = 1'b1;
        if (q_last) begin
          instr_flush = 1'b1;
          state_nxt   = ST_ISR;
        end
      end

      ST_ISR: begin
        // req is ignored entirely here: no nesting, even if software sets GIE.
        irq_active = 1'b1;
        if (retfie_done) begin
          gie_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign vector_addr = VECTOR_ADDR;

`ifdef IRQ_LATENCY_CNT_EN
  logic [7:0] pend_cnt;

  // pend_cnt restarts on the IDLE->PEND edge and steps on every edge taken
  // while in PEND, including the exit edge, so it equals clocks spent there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt    <= 8'd0;
      irq_latency <= 8'd0;
    end else begin
      if ((state != ST_PEND) && (state_nxt == ST_PEND)) begin
        pend_cnt <= 8'd0;
      end else if ((state == ST_PEND) && (pend_cnt != 8'hFF)) begin
        pend_cnt <= pend_cnt + 8'd1;
      end
      if ((state == ST_INJ1) && q_last) begin
        irq_latency <= pend_cnt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sequencer
// Purpose  : Self-checking bench for irq_sequencer. A table of per-cycle
//            input/expected-output records is applied through a scoreboard
//            queue; hand-written sequences cover asynchronous reset during
//            injection and (with IRQ_LATENCY_CNT_EN) the latency counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

  localparam int NUM_IRQ  = 4;
  localparam int PC_WIDTH = 13;

  // Packed output order: {irq_active, force_nop, stack_push, pc_load_vector,
  //                       gie_clr, instr_flush, gie_set}
  localparam logic [6:0] O_IDLE = 7'h00;
  localparam logic [6:0] O_INJ  = 7'h60;
  localparam logic [6:0] O_ENTR = 7'h7C;
  localparam logic [6:0] O_FLSH = 7'h62;
  localparam logic [6:0] O_ISR  = 7'h40;
  localparam logic [6:0] O_RETI = 7'h41;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          q_count;
  logic [NUM_IRQ-1:0]  irq_flags;
  logic [NUM_IRQ-1:0]  irq_enables;
  logic                gie;
  logic                instr_done;
  logic                instr_is_retfie;
  logic                force_nop;
  logic                stack_push;
  logic                pc_load_vector;
  logic [PC_WIDTH-1:0] vector_addr;
  logic                instr_flush;
  logic                gie_clr;
  logic                gie_set;
  logic                irq_active;
`ifdef IRQ_LATENCY_CNT_EN
  logic [7:0]          irq_latency;
`endif

  logic [6:0] outs;
  assign outs = {irq_active, force_nop, stack_push, pc_load_vector,
                 gie_clr, instr_flush, gie_set};

  irq_sequencer #(
    .NUM_IRQ     (NUM_IRQ),
    .PC_WIDTH    (PC_WIDTH),
    .VECTOR_ADDR (13'h004)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .q_count         (q_count),
    .irq_flags       (irq_flags),
    .irq_enables     (irq_enables),
    .gie             (gie),
    .instr_done      (instr_done),
    .instr_is_retfie (instr_is_retfie),
    .force_nop       (force_nop),
    .stack_push      (stack_push),
    .pc_load_vector  (pc_load_vector),
    .vector_addr     (vector_addr),
    .instr_flush     (instr_flush),
    .gie_clr         (gie_clr),
    .gie_set         (gie_set),
`ifdef IRQ_LATENCY_CNT_EN
    .irq_latency     (irq_latency),
`endif
    .irq_active      (irq_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] en;
    logic       gie;
    logic       done;
    logic       retfie;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl [256];
  int         n_vec = 0;
  logic [6:0] sb [$];
  logic [1:0] qc = 2'd0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic add(input logic [3:0] f, input logic [3:0] e, input logic g,
                     input logic d, input logic r, input logic [6:0] x);
    tbl[n_vec] = '{flags: f, en: e, gie: g, done: d, retfie: r, exp: x};
    n_vec++;
  endtask

  task automatic add_rep(input int n, input logic [3:0] f, input logic [3:0] e,
                         input logic g, input logic [6:0] x);
    for (int k = 0; k < n; k++) add(f, e, g, 1'b0, 1'b0, x);
  endtask

  // Drive one clock's inputs at the falling edge; return 1 time unit later
  // with the outputs of that cycle settled.
  task automatic tick(input logic [3:0] f, input logic [3:0] e, input logic g,
                      input logic d, input logic r);
    @(negedge clk);
    irq_flags       = f;
    irq_enables     = e;
    gie             = g;
    instr_done      = d;
    instr_is_retfie = r;
    q_count         = qc;
    qc              = qc + 2'd1;
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] e;
    bit         seen;

    rst = 1'b1;
    q_count = 2'd0; irq_flags = '0; irq_enables = '0; gie = 1'b0;
    instr_done = 1'b0; instr_is_retfie = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 0, {9'd0, outs}, {9'd0, O_IDLE});
    check("vector_addr", 0, {3'd0, vector_addr}, 16'h0004);
`ifdef IRQ_LATENCY_CNT_EN
    check("reset_latency", 0, {8'd0, irq_latency}, 16'd0);
`endif
    rst = 1'b0;

    // ---------------- vector table (q phase = entry index mod 4) ----------
    add(4'h0, 4'h1, 1, 0, 0, O_IDLE);           // q0 idle
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);           // q1 flag rises -> PEND
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);           // q2 pending
    add(4'h1, 4'h1, 1, 1, 0, O_IDLE);           // q3 boundary -> INJ1
    add(4'h1, 4'h1, 1, 0, 0, O_INJ);            // INJ1 q0
    add(4'h1, 4'h1, 1, 1, 0, O_INJ);            // q1: instr_done ignored
    add(4'h0, 4'h1, 1, 0, 0, O_INJ);            // q2: req drop ignored
    add(4'h0, 4'h1, 1, 0, 0, O_ENTR);           // q3 push/vector/gie_clr
    add_rep(3, 4'h0, 4'h1, 1, O_INJ);           // INJ2 q0..q2
    add(4'h0, 4'h1, 1, 0, 0, O_FLSH);           // INJ2 q3 flush
    add_rep(3, 4'h1, 4'h1, 1, O_ISR);           // ISR, req ignored
    add(4'h1, 4'h1, 1, 1, 0, O_ISR);            // non-RETFIE boundary
    add_rep(3, 4'h1, 4'h1, 1, O_ISR);
    add(4'h1, 4'h1, 1, 1, 1, O_RETI);           // RETFIE -> gie_set, IDLE
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);           // q0 idle, -> PEND at once
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);
    add(4'h1, 4'h1, 1, 1, 1, O_IDLE);           // RETFIE in PEND = boundary
    add_rep(3, 4'h0, 4'h1, 1, O_INJ);
    add(4'h0, 4'h1, 1, 0, 0, O_ENTR);
    add_rep(3, 4'h0, 4'h1, 1, O_INJ);
    add(4'h0, 4'h1, 1, 0, 0, O_FLSH);
    add_rep(3, 4'h0, 4'h1, 1, O_ISR);
    add(4'h0, 4'h1, 1, 1, 1, O_RETI);
    add(4'h1, 4'h1, 1, 0, 0, O_IDLE);           // q0 -> PEND
    add(4'h0, 4'h1, 1, 0, 0, O_IDLE);           // q1 cancel -> IDLE
    add(4'h0, 4'h1, 1, 0, 0, O_IDLE);
    add(4'h0, 4'h1, 1, 1, 0, O_IDLE);           // boundary, nothing injected
    add_rep(4, 4'h0, 4'h1, 1, O_IDLE);
    add_rep(8, 4'h1, 4'h1, 0, O_IDLE);          // GIE low masks everything
    add_rep(32, 4'h2, 4'h1, 1, O_IDLE);         // flag without its enable

    qc = 2'd0;
    for (int i = 0; i < n_vec; i++) begin
      tick(tbl[i].flags, tbl[i].en, tbl[i].gie, tbl[i].done, tbl[i].retfie);
      sb.push_back(tbl[i].exp);
      e = sb.pop_front();
      check("vec", i, {9'd0, outs}, {9'd0, e});
    end

    // ---------------- asynchronous reset in INJ1 Q1 ------------------------
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      tick(4'h1, 4'h1, 1, (qc == 2'd3), 0);
      seen = force_nop;
    end
    check("reach_inj1", 0, {15'd0, seen}, 16'd1);
    tick(4'h0, 4'h1, 1, 0, 0);                  // INJ1 q1
    check("inj1_q1", 0, {9'd0, outs}, {9'd0, O_INJ});
    #2 rst = 1'b1;
    #1 check("async_rst", 0, {9'd0, outs}, {9'd0, O_IDLE});
    for (int k = 0; k < 3; k++) begin
      tick(4'h0, 4'h1, 1, (qc == 2'd3), 0);
      check("in_rst", k, {9'd0, outs}, {9'd0, O_IDLE});
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(4'h0, 4'h1, 1, (qc == 2'd3), 0);
      check("after_rst", k, {9'd0, outs}, {9'd0, O_IDLE});
    end

`ifdef IRQ_LATENCY_CNT_EN
    // ---------------- latency counter --------------------------------------
    while (qc != 2'd1) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h1, 4'h1, 1, 0, 0);                  // IDLE q1 -> PEND
    for (int k = 0; k < 5; k++) tick(4'h1, 4'h1, 1, 0, 0);
    tick(4'h1, 4'h1, 1, 1, 0);                  // 6th PEND clk, boundary
    for (int k = 0; k < 4; k++) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h0, 4'h1, 1, 0, 0);                  // INJ2 q0
    check("latency6", 0, {8'd0, irq_latency}, 16'd6);
    while (qc != 2'd3) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h0, 4'h1, 1, 0, 0);                  // INJ2 q3
    while (qc != 2'd3) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h0, 4'h1, 1, 1, 1);                  // RETFIE
    while (qc != 2'd3) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h1, 4'h1, 1, 0, 0);                  // IDLE q3 -> PEND
    for (int k = 0; k < 299; k++) tick(4'h1, 4'h1, 1, 0, 0);
    tick(4'h1, 4'h1, 1, 1, 0);                  // 300th PEND clk, boundary
    tick(4'h0, 4'h1, 1, 0, 0);                  // INJ1 q0, value still held
    check("latency_hold", 0, {8'd0, irq_latency}, 16'd6);
    for (int k = 0; k < 3; k++) tick(4'h0, 4'h1, 1, 0, 0);
    tick(4'h0, 4'h1, 1, 0, 0);                  // INJ2 q0
    check("latency_sat", 0, {8'd0, irq_latency}, 16'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
